arm_regfile_16x32: RTL

- Architectural register file for the single-cycle ARM core: 16 entries × 32 bits, holding R0–R14 plus a virtual R15.
- Sits directly downstream of the 4-to-16 write-address decoder. The one-hot decoder output is the internal write-enable vector: exactly one register strobes per write port.
- Serves three combinational read ports: Rn, Rm, and Rs/Rd-store.
- Provides a second write port for base-register writeback on LDR/STR with writeback.

---
 rtl/arm_regfile_16x32.sv | 103 ++++++++++
 1 files changed

// File: rtl/arm_regfile_16x32.sv
// ARM architectural register file: R0-R14 stored in flops, R15 read from the
// PC+8 input. There are three combinational read ports and two write ports.
// Port 3 is the result port and has priority. Port 4 is the base-register
// writeback port. Writes to R15 are not stored; they come out as a
// registered pc_wr/pc_wd pulse. wr_count is a saturating count of committed
// writes to R0-R14.
module arm_regfile_16x32 #(
   parameter int WIDTH  = 32,
   parameter int BYPASS = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       ra1,
   input  logic [3:0]       ra2,
   input  logic [3:0]       ra3,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic [WIDTH-1:0] rd3,
   input  logic [WIDTH-1:0] r15,
   input  logic             we3,
   input  logic [3:0]       wa3,
   input  logic [WIDTH-1:0] wd3,
   input  logic             we4,
   input  logic [3:0]       wa4,
   input  logic [WIDTH-1:0] wd4,
   output logic             pc_wr,
   output logic [WIDTH-1:0] pc_wd,
   output logic [7:0]       wr_count
);

   logic [WIDTH-1:0] regs [0:14];

   // One-hot write strobes. Gating with the enable keeps an X address
   // from reaching the array while the port is idle.
   logic [15:0] sel3;
   logic [15:0] sel4;
   assign sel3 = we3 ? (16'd1 << wa3) : 16'd0;
   assign sel4 = we4 ? (16'd1 << wa4) : 16'd0;

   // Count the distinct R0-R14 addresses written this edge. A collision
   // counts once because port 4 loses.
   logic       wr3_ok;
   logic       wr4_ok;
   logic [8:0] count_sum;
   assign wr3_ok    = we3 && (wa3 != 4'd15);
   assign wr4_ok    = we4 && (wa4 != 4'd15) && !(wr3_ok && (wa3 == wa4));
   assign count_sum = {1'b0, wr_count} + {8'd0, wr3_ok} + {8'd0, wr4_ok};

   // Register array update. Port 3 wins when both ports hit the same entry.
   // NOTE: the array is reset because software may read R0-R14 straight
   // out of reset and must see zero. A RAM macro cannot do this.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 15; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments on every flop, so all state
         // updates together at the edge, regardless of statement order.
         for (int i = 0; i < 15; i++) begin
            if (sel3[i])      regs[i] <= wd3;
            else if (sel4[i]) regs[i] <= wd4;
         end
      end
   end

   // R15 write pulse. The data register holds its value between pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_wr <= 1'b0;
         pc_wd <= '0;
      end else begin
         pc_wr <= sel3[15] | sel4[15];
         if (sel3[15])      pc_wd <= wd3;
         else if (sel4[15]) pc_wd <= wd4;
      end
   end

   // Saturating write counter. A carry out of bit 7 means it saturates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wr_count <= 8'd0;
      else          wr_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
   end

   // Shared read mux. Address 15 is always the PC input. With write-through
   // enabled, a matching write this cycle supplies the data, port 3 first.
   function automatic logic [WIDTH-1:0] read_mux(input logic [3:0] addr);
      logic [WIDTH-1:0] val;
      if (addr == 4'd15)                  val = r15;
      else if (BYPASS != 0 && sel3[addr]) val = wd3;
      else if (BYPASS != 0 && sel4[addr]) val = wd4;
      else                                val = regs[addr];
      return val;
   endfunction

   // Combinational read ports, zero latency.
   // NOTE: each output is assigned on every path through the block, so no
   // latch can be inferred.
   always_comb begin
      rd1 = read_mux(ra1);
      rd2 = read_mux(ra2);
      rd3 = read_mux(ra3);
   end

endmodule
